// File: rtl/capture_sequencer.sv
// Capture session controller: arms a channel, waits out the run phase, then drains the FIFO as
// sync byte, LSB-first data words and a count/flags trailer. Define TX_CHECKSUM_EN to append an XOR byte.
`timescale 1ns/1ps
module capture_sequencer #(
  parameter int         DATA_W      = 32,
  parameter int         CNT_W       = 16,
  parameter int         ARM_TIMEOUT = 25000000,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
  input  logic              i_clk,
  input  logic              _mrst,
  input  logic              i_start,
  input  logic              i_abort,
  output logic              o_arm,
  input  logic              i_run,
  input  logic              i_fifo_empty,
  input  logic              i_fifo_full,
  output logic              o_fifo_rdreq,
  input  logic [DATA_W-1:0] i_fifo_q,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_word_count
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = ($clog2(NB) > 2) ? $clog2(NB) : 2;
  localparam int TMO_W = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST  = (ARM_TIMEOUT > 0) ? TMO_W'(ARM_TIMEOUT - 1) : '0;
  localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(NB - 1);
`ifdef TX_CHECKSUM_EN
  localparam logic [IDX_W-1:0] TRL_LAST  = IDX_W'(3);
`else
  localparam logic [IDX_W-1:0] TRL_LAST  = IDX_W'(2);
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_ARM, S_CAPTURE, S_HDR, S_RDREQ, S_RDWAIT, S_SEND, S_TRL, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [1:0]         flags_q, flags_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [15:0]        cnt16;
  logic               tx_hs;
`ifdef TX_CHECKSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign cnt16        = 16'(count_q);
  assign o_arm        = (state_q == S_ARM) || (state_q == S_CAPTURE);
  assign o_busy       = (state_q != S_IDLE);
  assign o_word_count = count_q;
  assign tx_hs        = o_tx_valid & i_tx_ready;

  // Byte presented to the host depends only on registered state, so it holds while stalled.
  always_comb begin
    o_tx_valid = 1'b0;
    o_tx_data  = '0;
    case (state_q)
      S_HDR: begin
        o_tx_valid = 1'b1;
        o_tx_data  = SYNC_BYTE;
      end
      S_SEND: begin
        o_tx_valid = 1'b1;
        o_tx_data  = shift_q[7:0];
      end
      S_TRL: begin
        o_tx_valid = 1'b1;
        case (idx_q)
          IDX_W'(0): o_tx_data = cnt16[7:0];
          IDX_W'(1): o_tx_data = cnt16[15:8];
          IDX_W'(2): o_tx_data = {6'b0, flags_q};
`ifdef TX_CHECKSUM_EN
          default:   o_tx_data = csum_q;
`else
          default:   o_tx_data = {6'b0, flags_q};
`endif
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    flags_d      = flags_q;
    count_d      = count_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    o_fifo_rdreq = 1'b0;
`ifdef TX_CHECKSUM_EN
    csum_d       = tx_hs ? (csum_q ^ o_tx_data) : csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_ARM;
          tmo_d   = '0;
          flags_d = '0;
          count_d = '0;
`ifdef TX_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_ARM: begin
        if (i_abort) begin
          state_d = S_HDR;
        end else if (i_run) begin
          state_d = S_CAPTURE;
        end else if ((ARM_TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
          flags_d[1] = 1'b1;
          state_d    = S_HDR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_CAPTURE: begin
        if (i_fifo_full) flags_d[0] = 1'b1;
        if (i_abort || !i_run || i_fifo_full) state_d = S_HDR;
      end
      S_HDR: begin
        if (tx_hs) state_d = S_RDREQ;
      end
      S_RDREQ: begin
        if (i_fifo_empty) begin
          idx_d   = '0;
          state_d = S_TRL;
        end else begin
          o_fifo_rdreq = 1'b1;
          state_d      = S_RDWAIT;
        end
      end
      S_RDWAIT: begin
        shift_d = i_fifo_q;
        idx_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (tx_hs) begin
          shift_d = shift_q >> 8;
          idx_d   = idx_q + 1'b1;
          if (idx_q == WORD_LAST) begin
            count_d = sat_inc(count_q);
            state_d = S_RDREQ;
          end
        end
      end
      S_TRL: begin
        if (tx_hs) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == TRL_LAST) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge _mrst) begin
    if (!_mrst) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      flags_q <= '0;
      count_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      flags_q <= flags_d;
      count_q <= count_d;
      idx_q   <= idx_d;
    end
  end

  // Datapath registers are always loaded before use within a session, so they carry no reset.
  always_ff @(posedge i_clk) begin
    shift_q <= shift_d;
`ifdef TX_CHECKSUM_EN
    csum_q  <= csum_d;
`endif
  end

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: FIFO model plus byte scoreboard filled as words are loaded.
`timescale 1ns/1ps
module tb_capture_sequencer;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam int TMO    = 20;
  localparam int NB     = DATA_W / 8;

  logic              i_clk = 1'b0;
  logic              _mrst = 1'b0;
  logic              i_start = 1'b0;
  logic              i_abort = 1'b0;
  logic              i_run = 1'b0;
  logic              i_fifo_full = 1'b0;
  logic              i_tx_ready = 1'b1;
  logic [DATA_W-1:0] fifo_q = '0;
  logic              i_fifo_empty;
  logic              o_arm, o_fifo_rdreq, o_tx_valid, o_busy;
  logic [7:0]        o_tx_data;
  logic [CNT_W-1:0]  o_word_count;

  logic [DATA_W-1:0] fifo[$];
  logic [7:0]        exp_q[$];
  int                wr_cnt = 0;
  int                rd_cnt = 0;
  int                n_chk = 0;
  int                n_pass = 0;
  int                bytes_seen = 0;
  logic              stall_prev = 1'b0;
  logic [7:0]        prev_data = '0;

  capture_sequencer #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .ARM_TIMEOUT(TMO), .SYNC_BYTE(8'hA5)
  ) dut (
    .i_clk(i_clk), ._mrst(_mrst), .i_start(i_start), .i_abort(i_abort),
    .o_arm(o_arm), .i_run(i_run), .i_fifo_empty(i_fifo_empty), .i_fifo_full(i_fifo_full),
    .o_fifo_rdreq(o_fifo_rdreq), .i_fifo_q(fifo_q), .o_tx_data(o_tx_data),
    .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready), .o_busy(o_busy),
    .o_word_count(o_word_count)
  );

  always #5 i_clk = ~i_clk;

  assign i_fifo_empty = (wr_cnt == rd_cnt);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got %0h, want %0h", tag, obs, expv);
  endtask

  // Normal-mode FIFO: data appears the cycle after the read request.
  always @(posedge i_clk) begin
    if (_mrst && o_fifo_rdreq) begin
      chk("rd_nonempty", 32'(wr_cnt != rd_cnt), 32'd1);
      if (fifo.size() > 0) begin
        fifo_q <= fifo.pop_front();
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  always @(negedge i_clk) begin
    if (_mrst) begin
      if (stall_prev) chk("hold", {23'b0, o_tx_valid, o_tx_data}, {23'b0, 1'b1, prev_data});
      stall_prev <= o_tx_valid && !i_tx_ready;
      prev_data  <= o_tx_data;
      if (o_tx_valid && i_tx_ready) begin
        bytes_seen <= bytes_seen + 1;
        if (exp_q.size() == 0) chk("extra_byte", {24'b0, o_tx_data}, 32'h100);
        else chk("tx_byte", {24'b0, o_tx_data}, {24'b0, exp_q.pop_front()});
      end
    end else begin
      stall_prev <= 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic load(input int n, input logic [1:0] flags);
    logic [DATA_W-1:0] w;
    logic [7:0]        x;
    logic [7:0]        t[3];
    x = 8'hA5;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      fifo.push_back(w);
      wr_cnt++;
      for (int b = 0; b < NB; b++) begin
        exp_q.push_back(w[8*b +: 8]);
        x ^= w[8*b +: 8];
      end
    end
    t[0] = 8'(n);
    t[1] = 8'(n >> 8);
    t[2] = {6'b0, flags};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(t[i]);
      x ^= t[i];
    end
`ifdef TX_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    step(1);
    i_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (o_busy && n < 3000) begin
      step(1);
      n++;
    end
    chk({tag, "_idle"}, {31'b0, o_busy}, 32'd0);
  endtask

  task automatic wait_bytes(input string tag, input int target);
    int n;
    n = 0;
    while (bytes_seen < target && n < 500) begin
      step(1);
      n++;
    end
    chk({tag, "_bytes"}, 32'(bytes_seen >= target), 32'd1);
  endtask

  task automatic end_of_frame(input string tag, input int words);
    chk({tag, "_count"}, {16'b0, o_word_count}, 32'(words));
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_fifo_drained"}, 32'(wr_cnt - rd_cnt), 32'd0);
  endtask

  initial begin
    int b0;
    int n;
    step(2);
    chk("rst_arm", {31'b0, o_arm}, 0);
    chk("rst_rdreq", {31'b0, o_fifo_rdreq}, 0);
    chk("rst_valid", {31'b0, o_tx_valid}, 0);
    chk("rst_busy", {31'b0, o_busy}, 0);
    chk("rst_data", {24'b0, o_tx_data}, 0);
    chk("rst_count", {16'b0, o_word_count}, 0);
    _mrst = 1'b1;
    step(2);

    // normal session, three words
    load(3, 2'b00);
    pulse_start();
    chk("t1_arm", {31'b0, o_arm}, 1);
    chk("t1_busy", {31'b0, o_busy}, 1);
    i_run = 1'b1;
    step(10);
    i_run = 1'b0;
    wait_idle("t1");
    end_of_frame("t1", 3);

    // backpressure in the middle of the first word
    load(2, 2'b00);
    b0 = bytes_seen;
    pulse_start();
    i_run = 1'b1;
    step(3);
    i_run = 1'b0;
    wait_bytes("t2", b0 + 3);
    i_tx_ready = 1'b0;
    step(5);
    chk("t2_stall_valid", {31'b0, o_tx_valid}, 1);
    i_tx_ready = 1'b1;
    wait_idle("t2");
    end_of_frame("t2", 2);

    // overflow during capture
    load(2, 2'b01);
    pulse_start();
    i_run = 1'b1;
    step(3);
    chk("t3_arm_capture", {31'b0, o_arm}, 1);
    i_fifo_full = 1'b1;
    step(1);
    i_fifo_full = 1'b0;
    chk("t3_arm_drop", {31'b0, o_arm}, 0);
    i_run = 1'b0;
    wait_idle("t3");
    end_of_frame("t3", 2);

    // arm timeout, run never rises
    load(0, 2'b10);
    pulse_start();
    n = 0;
    while (o_arm && n < 100) begin
      n++;
      step(1);
    end
    chk("t4_arm_cycles", 32'(n), 32'(TMO));
    wait_idle("t4");
    end_of_frame("t4", 0);

    // abort with one word stored, start ignored while sending
    load(1, 2'b00);
    b0 = bytes_seen;
    pulse_start();
    i_run = 1'b1;
    step(3);
    i_abort = 1'b1;
    step(1);
    i_abort = 1'b0;
    i_run = 1'b0;
    chk("t5_arm_drop", {31'b0, o_arm}, 0);
    wait_bytes("t5", b0 + 2);
    pulse_start();
    wait_idle("t5");
    end_of_frame("t5", 1);
    step(5);
    chk("t5_no_restart", {31'b0, o_busy}, 0);

    // start and abort together in IDLE: start wins
    load(0, 2'b00);
    i_start = 1'b1;
    i_abort = 1'b1;
    step(1);
    i_start = 1'b0;
    i_abort = 1'b0;
    chk("t5b_armed", {31'b0, o_arm}, 1);
    i_run = 1'b1;
    step(2);
    i_run = 1'b0;
    wait_idle("t5b");
    end_of_frame("t5b", 0);

    // asynchronous reset mid-word, then a clean session
    load(2, 2'b00);
    b0 = bytes_seen;
    pulse_start();
    i_run = 1'b1;
    step(2);
    i_run = 1'b0;
    wait_bytes("t6", b0 + 3);
    _mrst = 1'b0;
    #1;
    chk("t6_rst_valid", {31'b0, o_tx_valid}, 0);
    chk("t6_rst_busy", {31'b0, o_busy}, 0);
    chk("t6_rst_arm", {31'b0, o_arm}, 0);
    chk("t6_rst_data", {24'b0, o_tx_data}, 0);
    chk("t6_rst_count", {16'b0, o_word_count}, 0);
    chk("t6_rst_rdreq", {31'b0, o_fifo_rdreq}, 0);
    exp_q.delete();
    fifo.delete();
    wr_cnt = rd_cnt;
    step(2);
    _mrst = 1'b1;
    step(2);
    load(1, 2'b00);
    pulse_start();
    i_run = 1'b1;
    step(2);
    i_run = 1'b0;
    wait_idle("t6b");
    end_of_frame("t6b", 1);

    step(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
